// File: rtl/ctrl_pkt_gen.sv
// Control packet generator: emits VLAN/IPv4/UDP reconfiguration packets on a 256b AXI-Stream.
// Optional build macro CTRL_PKT_GEN_SEQ_EN adds a 32b sequence number to header beat 1.
module ctrl_pkt_gen #(
    parameter int         C_S_AXIS_DATA_WIDTH  = 256,
    parameter int         C_S_AXIS_TUSER_WIDTH = 128,
    parameter logic [7:0] SRC_PORT             = 8'h01
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic [11:0]                       req_vlan_id,
    input  logic [2:0]                        req_nbeats,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    pl_tdata,
    input  logic                              pl_tvalid,
    output logic                              pl_tready,
    input  logic                              pl_tlast,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic                              m_axis_tlast,
    output logic [31:0]                       pkt_cnt,
    output logic                              len_err
);

    localparam int DW = C_S_AXIS_DATA_WIDTH;
    localparam int TW = C_S_AXIS_TUSER_WIDTH;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HDR0    = 2'd1,
        HDR1    = 2'd2,
        PAYLOAD = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_nx;
    logic        adv_s;
    logic        req_fire_s;
    logic        load_hdr0_s;
    logic        load_hdr1_s;
    logic        load_pl_s;
    logic        clear_valid_s;
    logic [11:0] vlan_r;
    logic [2:0]  nbeats_r;
    logic [2:0]  pl_idx_r;
    logic [11:0] hdr_vlan_s;
    logic [2:0]  hdr_nb_s;
    logic [31:0] pkt_seq_s;

    function automatic logic [15:0] swap16(input logic [15:0] x);
        return {x[7:0], x[15:8]};
    endfunction

    function automatic logic [31:0] swap32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    // 64B of header beats plus 32B per payload beat
    function automatic logic [15:0] pkt_len(input logic [2:0] nb);
        return 16'd96 + {8'd0, nb, 5'd0};
    endfunction

    function automatic logic [DW-1:0] build_hdr0(input logic [11:0] vlan, input logic [2:0] nb);
        logic [DW-1:0] d;
        logic [15:0]   tci;
        tci          = {4'h0, vlan};
        d            = '0;
        d[111:96]    = 16'h0081;
        d[127:112]   = {tci[7:0], tci[15:8]};
        d[143:128]   = 16'h0008;
        d[151:144]   = 8'h45;
        d[175:160]   = swap16(pkt_len(nb) - 16'd18);
        d[215:208]   = 8'h40;
        d[223:216]   = 8'h11;
        return d;
    endfunction

    function automatic logic [DW-1:0] build_hdr1(input logic [2:0] nb, input logic [31:0] seq);
        logic [DW-1:0] d;
        d            = '0;
        d[63:48]     = 16'hf1f2;
        d[79:64]     = 16'hf2f1;
        d[95:80]     = swap16(pkt_len(nb) - 16'd38);
        d[143:112]   = swap32(seq);
        return d;
    endfunction

    function automatic logic [TW-1:0] build_tuser(input logic [2:0] nb);
        logic [TW-1:0] u;
        u            = '0;
        u[15:0]      = pkt_len(nb);
        u[23:16]     = SRC_PORT;
        return u;
    endfunction

    assign adv_s      = !m_axis_tvalid || m_axis_tready;
    assign req_ready  = (state_r == IDLE);
    assign pl_tready  = (state_r == PAYLOAD) && adv_s;
    // Beat 0 is built straight from the request when it can be loaded in the accept cycle
    assign hdr_vlan_s = (state_r == IDLE) ? req_vlan_id : vlan_r;
    assign hdr_nb_s   = (state_r == IDLE) ? req_nbeats  : nbeats_r;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Next-state and output-register load decisions
    always_comb begin
        state_nx      = state_r;
        req_fire_s    = 1'b0;
        load_hdr0_s   = 1'b0;
        load_hdr1_s   = 1'b0;
        load_pl_s     = 1'b0;
        clear_valid_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    req_fire_s = 1'b1;
                    if (adv_s) begin
                        load_hdr0_s = 1'b1;
                        state_nx    = HDR1;
                    end else begin
                        state_nx    = HDR0;
                    end
                end else if (adv_s) begin
                    clear_valid_s = 1'b1;
                end else begin
                    state_nx = IDLE;
                end
            end
            HDR0: begin
                if (adv_s) begin
                    load_hdr0_s = 1'b1;
                    state_nx    = HDR1;
                end else begin
                    state_nx    = HDR0;
                end
            end
            HDR1: begin
                if (adv_s) begin
                    load_hdr1_s = 1'b1;
                    state_nx    = PAYLOAD;
                end else begin
                    state_nx    = HDR1;
                end
            end
            PAYLOAD: begin
                if (adv_s && pl_tvalid) begin
                    load_pl_s = 1'b1;
                    if (pl_idx_r == nbeats_r) begin
                        state_nx = IDLE;
                    end else begin
                        state_nx = PAYLOAD;
                    end
                end else if (adv_s) begin
                    clear_valid_s = 1'b1;
                end else begin
                    state_nx = PAYLOAD;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Output register, request latches, counters and length check
    always_ff @(posedge clk) begin
        if (reset) begin
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tuser  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            vlan_r        <= 12'd0;
            nbeats_r      <= 3'd0;
            pl_idx_r      <= 3'd0;
            pkt_cnt       <= 32'd0;
            len_err       <= 1'b0;
        end else begin
            if (req_fire_s) begin
                vlan_r   <= req_vlan_id;
                nbeats_r <= req_nbeats;
            end
            if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
                pkt_cnt <= pkt_cnt + 32'd1;
            end
            if (load_hdr0_s) begin
                m_axis_tdata  <= build_hdr0(hdr_vlan_s, hdr_nb_s);
                m_axis_tuser  <= build_tuser(hdr_nb_s);
                m_axis_tkeep  <= '1;
                m_axis_tvalid <= 1'b1;
                m_axis_tlast  <= 1'b0;
                pl_idx_r      <= 3'd0;
            end else if (load_hdr1_s) begin
                m_axis_tdata  <= build_hdr1(nbeats_r, pkt_seq_s);
                m_axis_tkeep  <= '1;
                m_axis_tvalid <= 1'b1;
                m_axis_tlast  <= 1'b0;
            end else if (load_pl_s) begin
                m_axis_tdata  <= pl_tdata;
                m_axis_tkeep  <= '1;
                m_axis_tvalid <= 1'b1;
                m_axis_tlast  <= (pl_idx_r == nbeats_r);
                pl_idx_r      <= pl_idx_r + 3'd1;
                // framing follows the requested count; a mismatched pl_tlast is only flagged
                if (pl_tlast != (pl_idx_r == nbeats_r)) begin
                    len_err <= 1'b1;
                end
            end else if (clear_valid_s) begin
                m_axis_tvalid <= 1'b0;
                m_axis_tlast  <= 1'b0;
            end
        end
    end

`ifdef CTRL_PKT_GEN_SEQ_EN
    logic [31:0] seq_r;
    logic [31:0] pkt_seq_r;

    // Sequence number per accepted request, frozen for the packet being built
    always_ff @(posedge clk) begin
        if (reset) begin
            seq_r     <= 32'd0;
            pkt_seq_r <= 32'd0;
        end else if (req_fire_s) begin
            pkt_seq_r <= seq_r;
            seq_r     <= seq_r + 32'd1;
        end
    end

    assign pkt_seq_s = pkt_seq_r;
`else
    assign pkt_seq_s = 32'd0;
`endif

endmodule
